// File: rtl/seq_detect_arbiter_if.sv
// Handshake bundle for seq_detect_arbiter: per-channel serial
// requests/grants, synchronous flush, and the tagged match pulse.
interface seq_detect_arbiter_if #(
  parameter int NCH = 4
);
  localparam int CHW = $clog2(NCH);

  logic           flush;
  logic [NCH-1:0] bit_in;
  logic [NCH-1:0] bit_vld;
  logic [NCH-1:0] bit_rdy;
  logic           match_vld;
  logic [CHW-1:0] match_ch;

  modport master (
    output flush, bit_in, bit_vld,
    input  bit_rdy, match_vld, match_ch
  );

  modport slave (
    input  flush, bit_in, bit_vld,
    output bit_rdy, match_vld, match_ch
  );
endinterface

// File: rtl/seq_detect_arbiter.sv
// One shared pattern matcher round-robin multiplexed over NCH channels.
// SEQ_DETECT_MATCH_COUNT_EN adds per-channel saturating match counters.
module seq_detect_arbiter #(
  parameter int               NCH     = 4,
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1001,
  localparam int              CHW     = $clog2(NCH)
) (
  input  logic                clk,
  input  logic                rst,
  seq_detect_arbiter_if.slave bus
`ifdef SEQ_DETECT_MATCH_COUNT_EN
  ,
  input  logic [CHW-1:0]      cnt_sel,
  output logic [7:0]          match_cnt
`endif
);

  localparam int FW = $clog2(PAT_W);
  localparam logic [FW-1:0] FULL = FW'(PAT_W - 1);

  logic [CHW-1:0]   ptr;
  logic [PAT_W-2:0] hist [NCH];
  logic [FW-1:0]    fill [NCH];
  logic             mvld;
  logic [CHW-1:0]   mch;

  logic [NCH-1:0]   gnt;
  logic [CHW-1:0]   g;
  logic             any;
  logic [CHW:0]     sum;
  logic [PAT_W-1:0] cand;
  logic             hit;

  // First requester at or after ptr, wrapping modulo NCH.
  always_comb begin
    gnt = '0;
    g   = '0;
    any = 1'b0;
    sum = '0;
    for (int k = 0; k < NCH; k++) begin
      sum = {1'b0, ptr} + (CHW+1)'(k);
      if (sum >= (CHW+1)'(NCH))
        sum = sum - (CHW+1)'(NCH);
      if (!any && bus.bit_vld[sum[CHW-1:0]]) begin
        any = 1'b1;
        g   = sum[CHW-1:0];
      end
    end
    if (bus.flush || rst)
      any = 1'b0;
    if (any)
      gnt[g] = 1'b1;
  end

  // A channel must have PAT_W bits behind it before it can hit.
  assign cand = {hist[g], bus.bit_in[g]};
  assign hit  = any && (cand == PATTERN)
             && (fill[g] == FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr  <= '0;
      mvld <= 1'b0;
      mch  <= '0;
      for (int i = 0; i < NCH; i++) begin
        hist[i] <= '0;
        fill[i] <= '0;
      end
    end else if (bus.flush) begin
      mvld <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        hist[i] <= '0;
        fill[i] <= '0;
      end
    end else if (any) begin
      hist[g] <= cand[PAT_W-2:0];
      if (fill[g] != FULL)
        fill[g] <= fill[g] + 1'b1;
      ptr  <= (g == CHW'(NCH - 1)) ? '0 : g + 1'b1;
      mvld <= hit;
      if (hit)
        mch <= g;
    end else begin
      mvld <= 1'b0;
    end
  end

  assign bus.bit_rdy   = gnt;
  assign bus.match_vld = mvld;
  assign bus.match_ch  = mch;

`ifdef SEQ_DETECT_MATCH_COUNT_EN
  logic [7:0] cnt [NCH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++)
        cnt[i] <= '0;
    end else if (bus.flush) begin
      for (int i = 0; i < NCH; i++)
        cnt[i] <= '0;
    end else if (hit && cnt[g] != 8'hff) begin
      cnt[g] <= cnt[g] + 8'd1;
    end
  end

  assign match_cnt = cnt[cnt_sel];
`endif

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// Randomized and directed bench for seq_detect_arbiter against a
// behavioural model; a second instance watches an all-zero pattern.
module tb_seq_detect_arbiter;
  localparam int NCH   = 4;
  localparam int PAT_W = 4;
  localparam logic [3:0] PAT_A = 4'b1001;
  localparam logic [3:0] PAT_B = 4'b0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_detect_arbiter_if #(.NCH(NCH)) ba ();
  seq_detect_arbiter_if #(.NCH(NCH)) bb ();

  assign bb.bit_in  = ba.bit_in;
  assign bb.bit_vld = ba.bit_vld;
  assign bb.flush   = ba.flush;

`ifdef SEQ_DETECT_MATCH_COUNT_EN
  logic [1:0] cnt_sel;
  logic [7:0] cnt_a;
  logic [7:0] cnt_b;
`endif

  seq_detect_arbiter #(
    .NCH(NCH), .PAT_W(PAT_W), .PATTERN(PAT_A)
  ) u_a (
    .clk(clk), .rst(rst), .bus(ba)
`ifdef SEQ_DETECT_MATCH_COUNT_EN
    , .cnt_sel(cnt_sel), .match_cnt(cnt_a)
`endif
  );

  seq_detect_arbiter #(
    .NCH(NCH), .PAT_W(PAT_W), .PATTERN(PAT_B)
  ) u_b (
    .clk(clk), .rst(rst), .bus(bb)
`ifdef SEQ_DETECT_MATCH_COUNT_EN
    , .cnt_sel(cnt_sel), .match_cnt(cnt_b)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  int ptr_m;
  int hist_m [NCH];
  int fill_m [NCH];
  int cnt_m  [NCH];
  int ea, eb, ea_ch, eb_ch;
  int hits2;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic model_reset();
    ptr_m = 0;
    ea = 0; eb = 0; ea_ch = 0; eb_ch = 0;
    for (int i = 0; i < NCH; i++) begin
      hist_m[i] = 0;
      fill_m[i] = 0;
      cnt_m[i]  = 0;
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input logic [NCH-1:0] v,
                      input logic [NCH-1:0] b,
                      input logic f);
    int g;
    int idx;
    logic [NCH-1:0] er;
    ba.bit_vld = v;
    ba.bit_in  = b;
    ba.flush   = f;
    #1;
    g = -1;
    if (!f)
      for (int k = 0; k < NCH; k++) begin
        idx = (ptr_m + k) % NCH;
        if (g < 0 && v[idx]) g = idx;
      end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("rdy_a", 32'(ba.bit_rdy), 32'(er));
    chk("rdy_b", 32'(bb.bit_rdy), 32'(er));
`ifdef SEQ_DETECT_MATCH_COUNT_EN
    chk("cnt", 32'(cnt_a), cnt_m[cnt_sel]);
`endif
    if (f) begin
      for (int i = 0; i < NCH; i++) begin
        hist_m[i] = 0;
        fill_m[i] = 0;
        cnt_m[i]  = 0;
      end
      ea = 0; eb = 0;
    end else if (g >= 0) begin
      hist_m[g] = (hist_m[g] * 2 + int'(b[g]))
                  % (1 << PAT_W);
      fill_m[g]++;
      ea = int'(fill_m[g] >= PAT_W
                && hist_m[g] == int'(PAT_A));
      eb = int'(fill_m[g] >= PAT_W
                && hist_m[g] == int'(PAT_B));
      if (ea != 0) begin
        ea_ch = g;
        if (cnt_m[g] < 255) cnt_m[g]++;
      end
      if (eb != 0) eb_ch = g;
      ptr_m = (g + 1) % NCH;
    end else begin
      ea = 0; eb = 0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("mvld_a", 32'(ba.match_vld), ea);
    chk("mch_a",  32'(ba.match_ch),  ea_ch);
    chk("mvld_b", 32'(bb.match_vld), eb);
    chk("mch_b",  32'(bb.match_ch),  eb_ch);
    if (ba.match_vld && ba.match_ch == 2'd2)
      hits2++;
  endtask

  // Asserted between edges: outputs must clear without a clock.
  task automatic do_reset();
    ba.bit_vld = '1;
    ba.flush   = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_vld", 32'(ba.match_vld), 0);
    chk("arst_ch",  32'(ba.match_ch),  0);
    chk("arst_rdy", 32'(ba.bit_rdy),   0);
    chk("arst_rdyb", 32'(bb.bit_rdy),  0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  int seq [4] = '{1, 0, 0, 1};
  int ov  [7] = '{1, 0, 0, 1, 0, 0, 1};

  initial begin
    rst = 1'b1;
    ba.bit_vld = '1;
    ba.bit_in  = '0;
    ba.flush   = 1'b0;
`ifdef SEQ_DETECT_MATCH_COUNT_EN
    cnt_sel = 2'd0;
`endif
    model_reset();
    hits2 = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_vld", 32'(ba.match_vld), 0);
    chk("rst_ch",  32'(ba.match_ch),  0);
    chk("rst_rdy", 32'(ba.bit_rdy),   0);
    rst = 1'b0;

    for (int s = 0; s < 4; s++)
      step(4'b0001, NCH'(seq[s]), 1'b0);
    chk("single_vld", 32'(ba.match_vld), 1);
    chk("single_ch",  32'(ba.match_ch),  0);

    do_reset();
    hits2 = 0;
    for (int s = 0; s < 7; s++)
      step(4'b0100, NCH'(ov[s] << 2), 1'b0);
    chk("overlap_n", hits2, 2);

    do_reset();
    for (int s = 0; s < 16; s++) begin
      step(4'b1111, {NCH{seq[s/4] != 0}}, 1'b0);
      if (s >= 12) begin
        chk("ilv_vld", 32'(ba.match_vld), 1);
        chk("ilv_ch",  32'(ba.match_ch), s - 12);
      end
    end

    do_reset();
    for (int n = 0; n < 5; n++) begin
      step(4'b0010, 4'b0000, 1'b0);
      chk("zero_prime", 32'(bb.match_vld),
          (n >= 3) ? 1 : 0);
    end

    do_reset();
    step(4'b1000, 4'b1000, 1'b0);
    step(4'b1000, 4'b0000, 1'b0);
    step(4'b1000, 4'b0000, 1'b0);
    step(4'b1000, 4'b0000, 1'b1);
    step(4'b1000, 4'b1000, 1'b0);
    chk("flush_nomatch", 32'(ba.match_vld), 0);
    for (int s = 0; s < 4; s++)
      step(4'b1000, NCH'(seq[s] << 3), 1'b0);
    chk("flush_rematch", 32'(ba.match_vld), 1);
    chk("flush_ch",      32'(ba.match_ch),  3);

    step(4'b1000, 4'b1000, 1'b0);
    step(4'b1000, 4'b0000, 1'b0);
    step(4'b1000, 4'b0000, 1'b0);
    do_reset();
    step(4'b1000, 4'b1000, 1'b0);
    chk("rst_nomatch", 32'(ba.match_vld), 0);

    for (int n = 0; n < 400; n++) begin
      logic [NCH-1:0] v;
      logic [NCH-1:0] b;
      v = NCH'($urandom);
      b = NCH'($urandom) & NCH'($urandom);
`ifdef SEQ_DETECT_MATCH_COUNT_EN
      cnt_sel = 2'($urandom_range(0, NCH - 1));
`endif
      if ($urandom_range(0, 63) == 0)
        do_reset();
      else
        step(v, b, $urandom_range(0, 15) == 0);
    end

`ifdef SEQ_DETECT_MATCH_COUNT_EN
    do_reset();
    cnt_sel = 2'd1;
    step(4'b0010, 4'b0010, 1'b0);
    for (int n = 0; n < 300; n++) begin
      step(4'b0010, 4'b0000, 1'b0);
      step(4'b0010, 4'b0000, 1'b0);
      step(4'b0010, 4'b0010, 1'b0);
    end
    #1;
    chk("cnt_sat", 32'(cnt_a), 255);
    cnt_sel = 2'd0;
    #1;
    chk("cnt_other", 32'(cnt_a), 0);
    step(4'b0000, 4'b0000, 1'b1);
    cnt_sel = 2'd1;
    #1;
    chk("cnt_flush", 32'(cnt_a), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_detect_arbiter.md
Name: seq_detect_arbiter

Overview:
- Time-multiplexes one shared bit-serial pattern matcher across NCH independent serial input channels.
- Keeps a private shift history per channel.
- Each cycle, a round-robin scheduler grants one requesting channel; that channel's bit is shifted into its history and compared against PATTERN.
- Matches are reported one cycle later, tagged with the channel index.

Parameters:
- NCH, 4, number of serial input channels (2..16).
- PAT_W, 4, pattern length in bits (2..16).
- PATTERN, 4'b1001, bit pattern to detect; MSB is the oldest bit received.
- CHW, $clog2(NCH), channel index width (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all channel histories and fill counts.
- bit_in  in  NCH  serial data bit, one per channel.
- bit_vld  in  NCH  per-channel request: bit_in[i] is valid.
- bit_rdy  out  NCH  per-channel grant, one-hot or zero; the bit is consumed when bit_vld[i] and bit_rdy[i] are both high.
- match_vld  out  1  one-cycle pulse: a match was detected.
- match_ch  out  CHW  channel index of the match; valid while match_vld is high.

Behaviour:
- Reset (rst=1, asynchronous):
  - ptr=0; all hist[i]=0; all fill[i]=0; match_vld=0; match_ch=0.
  - bit_rdy=0 while rst is high.
- Per-channel state: hist[i], PAT_W-1 bits (the last PAT_W-1 accepted bits); fill[i], a saturating count 0..PAT_W-1.
- Grant (combinational):
  - g = first index i with bit_vld[i]=1, scanning ptr, ptr+1, ... modulo NCH.
  - bit_rdy = one-hot(g). bit_rdy is all zero if no bit_vld is set, or if flush=1.
  - bit_rdy[i] may depend combinationally on bit_vld; bit_vld must not depend on bit_rdy.
- On a grant (posedge):
  - cand = {hist[g], bit_in[g]}.
  - hist[g] <= cand[PAT_W-2:0].
  - fill[g] <= min(fill[g]+1, PAT_W-1).
  - hit = (cand == PATTERN) and (fill[g] == PAT_W-1).
  - ptr <= (g+1) mod NCH.
  - match_vld <= hit; match_ch <= g when hit is 1, otherwise match_ch holds its value.
- No grant: ptr, hist and fill are unchanged; match_vld <= 0.
- Latency: match_vld rises on the clock edge after the completing bit is accepted (1 cycle).
- Overlapping matches are detected. With PATTERN=1001, the stream 1001001 gives two matches.
- Each channel's stream is independent; interleaving between channels never corrupts histories.
- Fairness: any continuously requesting channel is granted within NCH cycles.
- flush=1 (takes priority over grants):
  - No grant in that cycle.
  - All hist=0; all fill=0; match_vld <= 0.
  - ptr is unchanged.
  - A match pulse registered on the previous edge is still visible for its one cycle.
- rst mid-stream: all partial progress is lost. A subsequent match requires PAT_W fresh bits on that channel.
- Priming: a channel must accept PAT_W bits since reset or flush before it can match. This prevents PATTERN values containing leading zeros from falsely matching the reset history.

Optional Feature:
- Macro: SEQ_DETECT_MATCH_COUNT_EN.
- Defined:
  - Adds input cnt_sel[CHW-1:0] and output match_cnt[7:0].
  - Per-channel 8-bit counters increment on each match of that channel and saturate at 255.
  - match_cnt = counter[cnt_sel], combinational read.
  - rst and flush clear all counters. A match in the same cycle as flush is not counted.
- Undefined: no counters and no extra ports; core behaviour is identical.

Test Plan:
- Single channel: ch0 alone streams 1,0,0,1 on consecutive cycles -> one match_vld pulse with match_ch=0 one cycle after the 4th bit; bit_rdy=4'b0001 on every cycle.
- Overlap: ch2 alone streams 1001001 -> exactly two pulses with match_ch=2, after bits 4 and 7.
- Interleave/fairness: all four channels request continuously, each sending 1001 -> grants rotate 0,1,2,3,0,...; four match pulses on consecutive cycles with match_ch=0,1,2,3.
- Priming and zero pattern: set PATTERN=4'b0000; after reset send 0,0,0 on ch1 -> no match; 4th 0 -> match; 5th 0 -> another match.
- Flush and reset mid-stream: ch3 sends 1,0,0, then flush=1 for one cycle, then 1 -> no match; then sends 1,0,0,1 -> match. Repeat with rst asserted mid-stream -> outputs go to zero immediately, asynchronously.
- With SEQ_DETECT_MATCH_COUNT_EN: 300 matches on ch1 -> match_cnt=255 when cnt_sel=1 and 0 when cnt_sel=0; after flush, match_cnt=0.
